// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a one-hot grant and a hold-time limit.
// Latency: grant 1 cycle after request; one idle cycle after every release.
// Backpressure: non-owner requests wait until IDLE; an owner is forced off after MAX_HOLD cycles.
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state;
    logic [2:0]       last;
    logic [CNT_W-1:0] hold_cnt;

    logic [2:0] pick_idx;
    logic       pick_any;
    logic [2:0] cand;
    logic       owner_req;
    logic       at_limit;
    logic       release_now;
    logic       forced;

    // Search starts just after the previous owner, so it is tried last.
    always_comb begin
        pick_idx = 3'd0;
        pick_any = 1'b0;
        cand     = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            cand = last + 3'(k);
            if (!pick_any && req[cand]) begin
                pick_idx = cand;
                pick_any = 1'b1;
            end
        end
    end

    always_comb begin
        owner_req   = req[gnt_idx];
        at_limit    = (hold_cnt == HOLD_LAST);
        release_now = done || !owner_req || at_limit;
        forced      = at_limit && !done && owner_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 3'd7;
            hold_cnt  <= '0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (pick_any) begin
                        gnt_idx   <= pick_idx;
                        gnt       <= 8'b1 << pick_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        last      <= gnt_idx;
                        timeout   <= forced;
                        hold_cnt  <= '0;
                        state     <= IDLE;
                    end else begin
                        timeout <= 1'b0;
                        if (!at_limit)
                            hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomised and directed bench for rr_arbiter8 against a cycle-level owner/queue model.
module tb_rr_arbiter8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_vec = 0;
    int n_bad = 0;

    rr_arbiter8 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    // Model: owner (-1 = none), previous owner, and number of granted cycles so far.
    int m_owner   = -1;
    int m_last    = 7;
    int m_held    = 0;
    bit m_tmo     = 1'b0;
    bit m_started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_owner   = -1;
            m_last    = 7;
            m_held    = 0;
            m_tmo     = 1'b0;
            m_started = 1'b1;
        end else if (m_started) begin
            m_tmo = 1'b0;
            if (m_owner < 0) begin
                int p;
                p = -1;
                for (int k = 1; k <= 8; k++) begin
                    int c;
                    c = (m_last + k) % 8;
                    if (p < 0 && req[c]) p = c;
                end
                if (p >= 0) begin
                    m_owner = p;
                    m_held  = 1;
                end
            end else begin
                bit full;
                full = (m_held == MAX_HOLD);
                if (done || !req[m_owner] || full) begin
                    m_tmo   = full && !done && req[m_owner];
                    m_last  = m_owner;
                    m_owner = -1;
                    m_held  = 0;
                end else begin
                    m_held++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            logic [7:0] e_gnt;
            logic       e_vld;
            e_vld = (m_owner >= 0);
            e_gnt = e_vld ? (8'b1 << m_owner) : 8'h00;
            n_vec++;
            if (gnt !== e_gnt || gnt_valid !== e_vld || timeout !== m_tmo ||
                (e_vld && gnt_idx !== 3'(m_owner))) begin
                n_bad++;
                $display("FAIL model t=%0t: gnt=%h vld=%b idx=%0d tmo=%b, required gnt=%h vld=%b idx=%0d tmo=%b",
                         $time, gnt, gnt_valid, gnt_idx, timeout, e_gnt, e_vld,
                         (m_owner < 0) ? 0 : m_owner, m_tmo);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt;
        int exp_owner;
        bit sticky;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        cyc(2);
        rst = 1'b0;
        chk("reset_gnt", gnt, 8'h00);
        chk("reset_idx", {5'd0, gnt_idx}, 8'h00);
        chk("reset_vld", {7'd0, gnt_valid}, 8'h00);
        chk("reset_tmo", {7'd0, timeout}, 8'h00);

        // Requester 0 wins after reset.
        req = 8'h81;
        cyc(1);
        chk("t1_gnt", gnt, 8'h01);
        chk("t1_vld", {7'd0, gnt_valid}, 8'h01);

        // Full rotation with done pulses.
        req = 8'hFF;
        for (int i = 1; i <= 8; i++) begin
            exp_owner = i % 8;
            done = 1'b1;
            cyc(1);
            done = 1'b0;
            chk("t2_gap", gnt, 8'h00);
            cyc(1);
            chk("t2_owner", gnt, 8'b1 << exp_owner);
            chk("t2_idx", {5'd0, gnt_idx}, 8'(exp_owner));
        end
        req = 8'h00;
        cyc(2);

        // Hold limit: exactly MAX_HOLD cycles, then timeout, then regrant.
        req = 8'h10;
        cyc(1);
        cnt = 0;
        while (gnt == 8'h10 && cnt < 40) begin
            cnt++;
            cyc(1);
        end
        chk("t3_len", 8'(cnt), 8'(MAX_HOLD));
        chk("t3_gap", gnt, 8'h00);
        chk("t3_tmo", {7'd0, timeout}, 8'h01);
        cyc(1);
        chk("t3_regrant", gnt, 8'h10);
        chk("t3_tmo_clr", {7'd0, timeout}, 8'h00);
        req = 8'h00;
        cyc(2);

        // Owner drops its request.
        req = 8'h04;
        cyc(1);
        chk("t4_own2", gnt, 8'h04);
        req = 8'h0C;
        cyc(1);
        chk("t4_hold2", gnt, 8'h04);
        req = 8'h08;
        cyc(1);
        chk("t4_gap", gnt, 8'h00);
        cyc(1);
        chk("t4_own3", gnt, 8'h08);
        chk("t4_idx3", {5'd0, gnt_idx}, 8'h03);
        req = 8'h00;
        cyc(2);

        // done coincident with the hold limit is a normal release.
        req = 8'h01;
        cyc(1);
        chk("t5_own0", gnt, 8'h01);
        cyc(MAX_HOLD - 1);
        done = 1'b1;
        cyc(1);
        done = 1'b0;
        chk("t5_gap", gnt, 8'h00);
        chk("t5_no_tmo", {7'd0, timeout}, 8'h00);
        req  = 8'h00;
        done = 1'b1;
        cyc(2);
        chk("t5_idle_done", gnt, 8'h00);
        req = 8'h02;
        cyc(1);
        done = 1'b0;
        chk("t5_done_ignored", gnt, 8'h02);
        req = 8'h00;
        cyc(2);

        // Reset during a grant.
        req = 8'h20;
        cyc(1);
        chk("t6_own5", gnt, 8'h20);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t6_rst_gnt", gnt, 8'h00);
        chk("t6_rst_vld", {7'd0, gnt_valid}, 8'h00);
        chk("t6_rst_tmo", {7'd0, timeout}, 8'h00);
        req = 8'hFF;
        cyc(1);
        chk("t6_own0", gnt, 8'h01);

        // Random traffic, alternating sticky phases (to reach timeouts) with busy ones.
        sticky = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) sticky = ~sticky;
            if (sticky) begin
                if ($urandom_range(15) == 0) req = 8'($urandom);
                done = ($urandom_range(40) == 0);
            end else begin
                if ($urandom_range(2) == 0) req = 8'($urandom);
                done = ($urandom_range(5) == 0);
            end
            rst = ($urandom_range(700) == 0);
            cyc(1);
        end
        rst  = 1'b0;
        done = 1'b0;
        req  = 8'h00;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
